// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  // Writeback requester slots, index 0 has highest initial priority
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant: first valid requester at or after ptr (mod NUM_REQ).
// Also reports the winning index and the pointer value following it.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               anyGrant,
  output logic [PW-1:0]      grantIdx,
  output logic [PW-1:0]      nextPtr
);

  // Rotating priority scan starting at ptr; first hit wins
  always_comb begin
    int idx;
    grant    = '0;
    anyGrant = 1'b0;
    grantIdx = '0;
    nextPtr  = ptr;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!anyGrant && valid[idx]) begin
        anyGrant    = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = PW'(idx);
        nextPtr     = PW'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: zero-fills all registers after reset,
// then round-robins NUM_REQ writeback requesters onto registered wr_*
// outputs and tracks pending writes for decode hazard stalls.
// Optional build macro ZERO_REG_PROTECT_EN: in RUN, writes to register 0
// are accepted but dropped, and register 0 never reads as busy.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = regfile_pkg::AW,
  parameter int DW      = regfile_pkg::DW,
  parameter int NREGS   = regfile_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_rd,
  input  logic [AW-1:0]         rs_q,
  input  logic [AW-1:0]         rt_q,
  output logic                  busy_rs,
  output logic                  busy_rt,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DW-1:0]         wr_data,
  output logic                  init_done
);
  import regfile_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, stateNext;
  logic [AW-1:0]      cnt;
  logic [PW-1:0]      ptr, nextPtr, grantIdx;
  logic [NUM_REQ-1:0] grant;
  logic               anyGrant;
  logic               grantFire;
  logic               writeFire;
  logic [AW-1:0]      selAddr;
  logic [DW-1:0]      selData;
  logic               issSet;
  logic [NREGS-1:0]   busy;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) uArb (
    .valid    (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .anyGrant (anyGrant),
    .grantIdx (grantIdx),
    .nextPtr  (nextPtr)
  );

  assign selAddr   = req_addr[int'(grantIdx)*AW +: AW];
  assign selData   = req_data[int'(grantIdx)*DW +: DW];
  assign grantFire = (state == RUN) && anyGrant;
  assign req_ready = (state == RUN) ? grant : '0;

`ifdef ZERO_REG_PROTECT_EN
  // Register 0 is hard-wired: accept the grant but drop the write
  assign writeFire = grantFire && (selAddr != '0);
  assign issSet    = iss_valid && (iss_rd != '0);
  assign busy_rs   = (state == RUN) && (rs_q != '0) && busy[rs_q];
  assign busy_rt   = (state == RUN) && (rt_q != '0) && busy[rt_q];
`else
  assign writeFire = grantFire;
  assign issSet    = iss_valid;
  assign busy_rs   = (state == RUN) && busy[rs_q];
  assign busy_rt   = (state == RUN) && busy[rt_q];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= stateNext;
  end

  // Leave INIT once the last fill address has been loaded
  always_comb begin
    stateNext = state;
    case (state)
      INIT:    if (cnt == AW'(NREGS - 1)) stateNext = RUN;
      RUN:     stateNext = RUN;
      default: stateNext = INIT;
    endcase
  end

  // Fill sequencer and registered write port / rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ptr       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      init_done <= 1'b0;
    end else if (state == INIT) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt;
      wr_data <= '0;
      cnt     <= cnt + 1'b1;
      if (cnt == AW'(NREGS - 1)) init_done <= 1'b1;
    end else begin
      wr_en <= writeFire;
      if (grantFire) ptr <= nextPtr;
      if (writeFire) begin
        wr_addr <= selAddr;
        wr_data <= selData;
      end
    end
  end

  // Pending-write scoreboard; set is written last so it beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (state == RUN) begin
      if (wr_en)  busy[wr_addr] <= 1'b0;
      if (issSet) busy[iss_rd]  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as
// stimulus is issued and a negedge monitor pops one per wr_en cycle.
module tb_regfile_wb_arbiter;
  localparam int NUM_REQ = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  iss_valid = 1'b0;
  logic [AW-1:0]         iss_rd = '0;
  logic [AW-1:0]         rs_q = '0;
  logic [AW-1:0]         rt_q = '0;
  logic                  busy_rs, busy_rt, wr_en, init_done;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t expQ[$];
  int  nTests = 0;
  int  nFail  = 0;

  regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs_q(rs_q), .rt_q(rt_q),
    .busy_rs(busy_rs), .busy_rt(busy_rt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input int a, input int d);
    wr_t w;
    w.addr = AW'(a);
    w.data = DW'(d);
    expQ.push_back(w);
  endtask

  task automatic setReq(input int i, input int a, input int d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  // Monitor: every visible register-file write must match the next expected one
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t w;
      nTests++;
      if (expQ.size() == 0) begin
        nFail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", wr_addr, wr_data);
      end else begin
        w = expQ.pop_front();
        if (wr_addr !== w.addr || wr_data !== w.data) begin
          nFail++;
          $display("FAIL write: got (%0d,0x%0h) expected (%0d,0x%0h)", wr_addr, wr_data, w.addr, w.data);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    settle();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);

    // Zero-fill with all requesters pending: no grants until RUN
    req_valid = 3'b111;
    setReq(0, 5, 'hA); setReq(1, 6, 'hB); setReq(2, 7, 'hC);
    for (int a = 0; a < 32; a++) push(a, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(); settle();
      chk("fill_wr_en", 32'(wr_en), 1);
      chk("fill_init_done", 32'(init_done), (k == 32) ? 1 : 0);
      if (k < 32) chk("fill_ready", 32'(req_ready), 0);
    end
    // First RUN cycle: grant 0, then rotate one per cycle
    chk("rr_ready0", 32'(req_ready), 1);
    for (int r = 0; r < 2; r++) begin
      push(5, 'hA); push(6, 'hB); push(7, 'hC);
    end
    for (int j = 1; j <= 5; j++) begin
      cyc(); settle();
      chk("rr_ready", 32'(req_ready), 32'(1 << (j % 3)));
    end
    cyc(); req_valid = '0; settle();
    cyc(); settle();
    chk("idle_wr_en", 32'(wr_en), 0);

    // RAW hazard: issue rd=9, write it back two cycles later
    iss_valid = 1'b1; iss_rd = 9; rs_q = 9; rt_q = 10;
    settle();
    chk("busy_before_issue", 32'(busy_rs), 0);
    cyc(); iss_valid = 1'b0; settle();
    chk("busy_after_issue", 32'(busy_rs), 1);
    chk("busy_rt_other", 32'(busy_rt), 0);
    cyc();
    req_valid = 3'b010; setReq(1, 9, 'h99); push(9, 'h99);
    settle();
    chk("raw_ready", 32'(req_ready), 32'b010);
    chk("busy_at_grant", 32'(busy_rs), 1);
    cyc(); req_valid = '0; settle();
    chk("raw_wr_en", 32'(wr_en), 1);
    chk("busy_in_wr_cycle", 32'(busy_rs), 1);
    cyc(); settle();
    chk("busy_cleared", 32'(busy_rs), 0);

    // Same-cycle set and clear of reg 4: set wins
    req_valid = 3'b100; setReq(2, 4, 'h44); push(4, 'h44);
    rs_q = 4; rt_q = 9;
    settle();
    chk("sc_ready", 32'(req_ready), 32'b100);
    cyc(); req_valid = '0; iss_valid = 1'b1; iss_rd = 4; settle();
    chk("sc_wr_en", 32'(wr_en), 1);
    cyc(); iss_valid = 1'b0; settle();
    chk("sc_set_wins", 32'(busy_rs), 1);
    chk("sc_rt_clear", 32'(busy_rt), 0);
    req_valid = 3'b001; setReq(0, 4, 'h55); push(4, 'h55);
    settle();
    chk("sc_ready2", 32'(req_ready), 32'b001);
    cyc(); req_valid = '0; settle();
    chk("sc_busy_hold", 32'(busy_rs), 1);
    cyc(); settle();
    chk("sc_busy_clear", 32'(busy_rs), 0);

    // Leave reg 12 pending, then reset partway through a fresh fill
    iss_valid = 1'b1; iss_rd = 12; rt_q = 12;
    cyc(); iss_valid = 1'b0; settle();
    chk("busy12_set", 32'(busy_rt), 1);
    rst = 1'b1;
    cyc(); settle();
    chk("rst1_wr_en", 32'(wr_en), 0);
    chk("rst1_init_done", 32'(init_done), 0);
    chk("rst1_busy_rt", 32'(busy_rt), 0);
    rst = 1'b0;
    for (int a = 0; a < 10; a++) push(a, 0);
    iss_valid = 1'b1; iss_rd = 9; rs_q = 9;
    for (int k = 1; k <= 10; k++) begin
      cyc(); settle();
      chk("fill1_wr_en", 32'(wr_en), 1);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(); settle();
      chk("rst2_wr_en", 32'(wr_en), 0);
      chk("rst2_init_done", 32'(init_done), 0);
    end
    rst = 1'b0;
    for (int a = 0; a < 32; a++) push(a, 0);
    for (int k = 1; k <= 32; k++) begin
      cyc(); settle();
      chk("fill2_wr_en", 32'(wr_en), 1);
      chk("fill2_init_done", 32'(init_done), (k == 32) ? 1 : 0);
      chk("fill2_busy_rs", 32'(busy_rs), 0);
      if (k == 31) iss_valid = 1'b0;
    end

    // Write to register 0 from requester 2
    req_valid = 3'b100; setReq(2, 0, 'hFFFF);
`ifndef ZERO_REG_PROTECT_EN
    push(0, 'hFFFF);
`endif
    settle();
    chk("z_ready", 32'(req_ready), 32'b100);
    cyc(); req_valid = '0; settle();
`ifdef ZERO_REG_PROTECT_EN
    chk("z_wr_en", 32'(wr_en), 0);
`else
    chk("z_wr_en", 32'(wr_en), 1);
`endif
    req_valid = 3'b111; settle();
    chk("z_ptr_wrap", 32'(req_ready), 32'b001);
    req_valid = '0;
    iss_valid = 1'b1; iss_rd = 0; rs_q = 0;
    cyc(); iss_valid = 1'b0; settle();
`ifdef ZERO_REG_PROTECT_EN
    chk("z_busy0", 32'(busy_rs), 0);
`else
    chk("z_busy0", 32'(busy_rs), 1);
`endif

    cyc(); cyc(); settle();
    chk("queue_drained", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
